// File: rtl/cnn_runner_pkg.sv
// Shared types and default sizing for the CNN batch self-test sequencer.
package cnn_runner_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StReport,
    StGap,
    StFinish
  } run_state_e;

  localparam int unsigned DefSelW     = 4;
  localparam int unsigned DefClassW   = 8;
  localparam int unsigned DefMaxImg   = 16;
  localparam int unsigned DefStartLen = 10;
  localparam int unsigned DefTimeout  = 100000;
  localparam int unsigned DefGapCyc   = 1000;
  localparam int unsigned DefTmrW     = 20;

endpackage

// File: rtl/cnn_run_timer.sv
// Loadable down-counter shared by the START, WAIT and GAP phases of the batch runner.
module cnn_run_timer #(
  parameter int unsigned TMR_W = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [TMR_W-1:0] load_val,
  output logic             expire
);

  logic [TMR_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - TMR_W'(1);
    end
  end

  // Loading N-1 gives a phase of exactly N cycles ending on the expire cycle.
  assign expire = (count_q == '0);

endmodule

// File: rtl/cnn_batch_runner.sv
// Self-test sequencer: steps a batch of stored images through cnn_top, times each run out,
// reports per-image results and keeps pass/timeout statistics.
module cnn_batch_runner
  import cnn_runner_pkg::*;
#(
  parameter int unsigned SEL_W     = DefSelW,
  parameter int unsigned CLASS_W   = DefClassW,
  parameter int unsigned MAX_IMG   = DefMaxImg,
  parameter int unsigned START_LEN = DefStartLen,
  parameter int unsigned TIMEOUT   = DefTimeout,
  parameter int unsigned GAP_CYC   = DefGapCyc,
  parameter int unsigned TMR_W     = DefTmrW,
  localparam int unsigned CNT_W    = $clog2(MAX_IMG + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [SEL_W-1:0]   i_first_sel,
  input  logic [CNT_W-1:0]   i_num_img,
  input  logic               i_core_done,
  input  logic [CLASS_W-1:0] i_core_alpha,
  input  logic [CLASS_W-1:0] i_exp_alpha,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_core_valid,
  output logic               o_busy,
  output logic               o_res_valid,
  output logic [SEL_W-1:0]   o_res_sel,
  output logic [CLASS_W-1:0] o_res_alpha,
  output logic               o_res_match,
  output logic               o_res_tmo,
  output logic               o_done,
  output logic               o_aborted,
  output logic [CNT_W-1:0]   o_pass_cnt,
  output logic [CNT_W-1:0]   o_tmo_cnt
);

  localparam logic [TMR_W-1:0] StartLoad   = TMR_W'(START_LEN - 1);
  localparam logic [TMR_W-1:0] TimeoutLoad = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GapLoad     = (GAP_CYC == 0) ? '0 : TMR_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] MaxCnt      = CNT_W'(MAX_IMG);
  localparam bit               SkipGap     = (GAP_CYC == 0);

  run_state_e         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic               aborted_q, aborted_d;
  logic [SEL_W-1:0]   res_sel_q, res_sel_d;
  logic [CLASS_W-1:0] res_alpha_q, res_alpha_d;
  logic               res_match_q, res_match_d;
  logic               res_tmo_q, res_tmo_d;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_expire;
  logic [CNT_W-1:0]   num_clamped;

  assign num_clamped = (i_num_img > MaxCnt) ? MaxCnt : i_num_img;

  cnn_run_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .en       (state_q != StIdle),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rem_d       = rem_q;
    pass_d      = pass_q;
    tmo_d       = tmo_q;
    aborted_d   = aborted_q;
    res_sel_d   = res_sel_q;
    res_alpha_d = res_alpha_q;
    res_match_d = res_match_q;
    res_tmo_d   = res_tmo_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    // Abort outranks everything, including a completion seen in the same cycle.
    if (i_abort && (state_q != StIdle) && (state_q != StFinish)) begin
      state_d   = StFinish;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            sel_d     = i_first_sel;
            rem_d     = num_clamped;
            pass_d    = '0;
            tmo_d     = '0;
            aborted_d = 1'b0;
            if (num_clamped == '0) begin
              state_d = StFinish;
            end else begin
              state_d  = StStart;
              tmr_load = 1'b1;
              tmr_val  = StartLoad;
            end
          end
        end
        StStart: begin
          if (tmr_expire) begin
            state_d  = StWait;
            tmr_load = 1'b1;
            tmr_val  = TimeoutLoad;
          end
        end
        StWait: begin
          if (i_core_done || tmr_expire) begin
            state_d   = StReport;
            res_sel_d = sel_q;
            if (i_core_done) begin
              res_alpha_d = i_core_alpha;
              res_tmo_d   = 1'b0;
              res_match_d = (i_core_alpha == i_exp_alpha);
              if ((i_core_alpha == i_exp_alpha) && (pass_q != MaxCnt)) begin
                pass_d = pass_q + CNT_W'(1);
              end
            end else begin
              res_alpha_d = '0;
              res_tmo_d   = 1'b1;
              res_match_d = 1'b0;
              if (tmo_q != MaxCnt) begin
                tmo_d = tmo_q + CNT_W'(1);
              end
            end
          end
        end
        StReport: begin
          if (rem_q == CNT_W'(1)) begin
            state_d = StFinish;
          end else begin
            rem_d    = rem_q - CNT_W'(1);
            sel_d    = sel_q + SEL_W'(1);
            tmr_load = 1'b1;
            if (SkipGap) begin
              state_d = StStart;
              tmr_val = StartLoad;
            end else begin
              state_d = StGap;
              tmr_val = GapLoad;
            end
          end
        end
        StGap: begin
          if (tmr_expire) begin
            state_d  = StStart;
            tmr_load = 1'b1;
            tmr_val  = StartLoad;
          end
        end
        StFinish: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      rem_q       <= '0;
      pass_q      <= '0;
      tmo_q       <= '0;
      aborted_q   <= 1'b0;
      res_sel_q   <= '0;
      res_alpha_q <= '0;
      res_match_q <= 1'b0;
      res_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rem_q       <= rem_d;
      pass_q      <= pass_d;
      tmo_q       <= tmo_d;
      aborted_q   <= aborted_d;
      res_sel_q   <= res_sel_d;
      res_alpha_q <= res_alpha_d;
      res_match_q <= res_match_d;
      res_tmo_q   <= res_tmo_d;
    end
  end

  assign o_sel        = sel_q;
  assign o_core_valid = (state_q == StStart);
  assign o_busy       = (state_q == StStart) || (state_q == StWait) ||
                        (state_q == StReport) || (state_q == StGap);
  assign o_res_valid  = (state_q == StReport);
  assign o_res_sel    = res_sel_q;
  assign o_res_alpha  = res_alpha_q;
  assign o_res_match  = res_match_q;
  assign o_res_tmo    = res_tmo_q;
  assign o_done       = (state_q == StFinish);
  assign o_aborted    = aborted_q;
  assign o_pass_cnt   = pass_q;
  assign o_tmo_cnt    = tmo_q;

endmodule

// File: tb/tb_cnn_batch_runner.sv
// Directed bench for cnn_batch_runner with a latency-based cnn_top model and a result scoreboard.
module tb_cnn_batch_runner;

  localparam int unsigned SelW     = 4;
  localparam int unsigned ClassW   = 8;
  localparam int unsigned MaxImg   = 16;
  localparam int unsigned CntW     = 5;
  localparam int unsigned StartLen = 2;
  localparam int unsigned Timeout  = 50;
  localparam int unsigned GapCyc   = 3;
  localparam int          CoreLat  = 20;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              i_start = 1'b0;
  logic              i_abort = 1'b0;
  logic [SelW-1:0]   i_first_sel = '0;
  logic [CntW-1:0]   i_num_img = '0;
  logic              i_core_done = 1'b0;
  logic [ClassW-1:0] i_core_alpha = '0;
  logic [ClassW-1:0] i_exp_alpha;
  logic [SelW-1:0]   o_sel;
  logic              o_core_valid;
  logic              o_busy;
  logic              o_res_valid;
  logic [SelW-1:0]   o_res_sel;
  logic [ClassW-1:0] o_res_alpha;
  logic              o_res_match;
  logic              o_res_tmo;
  logic              o_done;
  logic              o_aborted;
  logic [CntW-1:0]   o_pass_cnt;
  logic [CntW-1:0]   o_tmo_cnt;

  always #5 clk = ~clk;

  cnn_batch_runner #(
    .SEL_W     (SelW),
    .CLASS_W   (ClassW),
    .MAX_IMG   (MaxImg),
    .START_LEN (StartLen),
    .TIMEOUT   (Timeout),
    .GAP_CYC   (GapCyc),
    .TMR_W     (20)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_first_sel  (i_first_sel),
    .i_num_img    (i_num_img),
    .i_core_done  (i_core_done),
    .i_core_alpha (i_core_alpha),
    .i_exp_alpha  (i_exp_alpha),
    .o_sel        (o_sel),
    .o_core_valid (o_core_valid),
    .o_busy       (o_busy),
    .o_res_valid  (o_res_valid),
    .o_res_sel    (o_res_sel),
    .o_res_alpha  (o_res_alpha),
    .o_res_match  (o_res_match),
    .o_res_tmo    (o_res_tmo),
    .o_done       (o_done),
    .o_aborted    (o_aborted),
    .o_pass_cnt   (o_pass_cnt),
    .o_tmo_cnt    (o_tmo_cnt)
  );

  typedef struct {
    int sel;
    int alpha;
    int match;
    int tmo;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   dead_sel = -1;
  int   wrong_sel = -1;
  int   slow_sel = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected-label table: deliberately wrong for wrong_sel.
  assign i_exp_alpha = (int'(o_sel) == wrong_sel) ? 8'h3F : 8'h41 + {4'h0, o_sel};

  // cnn_top model: answers 'A'+sel a fixed latency after its start strobe drops.
  logic            core_armed = 1'b0;
  int              core_cnt = 0;
  int              core_lat = CoreLat;
  logic [SelW-1:0] core_sel = '0;

  always @(negedge clk) begin
    i_core_done  = 1'b0;
    i_core_alpha = 8'hEE;
    if (!reset_n) begin
      core_armed = 1'b0;
    end else if (o_core_valid) begin
      core_armed = 1'b1;
      core_cnt   = 0;
      core_sel   = o_sel;
      core_lat   = (int'(o_sel) == slow_sel) ? int'(Timeout) : CoreLat;
    end else if (core_armed) begin
      core_cnt++;
      if (core_cnt == core_lat) begin
        core_armed = 1'b0;
        if (int'(core_sel) != dead_sel) begin
          i_core_done  = 1'b1;
          i_core_alpha = 8'h41 + {4'h0, core_sel};
        end
      end
    end
  end

  // Output monitor: strobe length, select stability, result scoreboard, done count.
  int              mon_run = 0;
  int              mon_wcyc = 0;
  logic            mon_prev_cv = 1'b0;
  logic [SelW-1:0] mon_cv_sel = '0;
  exp_t            mon_e;

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_run     = 0;
      mon_wcyc    = 0;
      mon_prev_cv = 1'b0;
    end else begin
      if (o_core_valid) begin
        if (!mon_prev_cv) begin
          mon_run    = 0;
          mon_cv_sel = o_sel;
        end
        mon_run++;
        mon_wcyc = 0;
        check("sel_stable", o_sel, mon_cv_sel);
      end else begin
        mon_wcyc++;
        if (mon_prev_cv) check("cv_len", mon_run, StartLen);
      end
      if (o_res_valid) begin
        check("res_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("res_sel", o_res_sel, mon_e.sel);
          check("res_alpha", o_res_alpha, mon_e.alpha);
          check("res_match", o_res_match, mon_e.match);
          check("res_tmo", o_res_tmo, mon_e.tmo);
          check("res_latency", mon_wcyc, mon_e.lat);
        end
      end
      if (o_done) done_cnt++;
      mon_prev_cv = o_core_valid;
    end
  end

  task automatic push_exp(input int s);
    exp_t e;
    e.sel   = s;
    e.tmo   = (s == dead_sel) ? 1 : 0;
    e.alpha = e.tmo ? 0 : 'h41 + s;
    e.match = (e.tmo == 0 && s != wrong_sel) ? 1 : 0;
    e.lat   = (e.tmo == 1 || s == slow_sel) ? int'(Timeout) + 1 : CoreLat + 1;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int limit);
    int c = 0;
    while (!o_done && c < limit) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", o_done, 1);
  endtask

  task automatic run_batch(input int first, input int num, input bit poke);
    int n;
    int s;
    int ep = 0;
    int et = 0;
    int d0;
    n = (num > int'(MaxImg)) ? int'(MaxImg) : num;
    for (int i = 0; i < n; i++) begin
      s = (first + i) % 16;
      push_exp(s);
      if (s == dead_sel) et++;
      else if (s != wrong_sel) ep++;
    end
    d0 = done_cnt;
    @(negedge clk);
    i_first_sel = 4'(first);
    i_num_img   = 5'(num);
    i_start     = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("cv_cycle1", o_core_valid, n != 0);
    check("busy_cycle1", o_busy, n != 0);
    if (poke) begin
      repeat (10) @(negedge clk);
      i_first_sel = 4'd9;
      i_num_img   = 5'd7;
      i_start     = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
    end
    wait_done(3000);
    check("busy_at_done", o_busy, 0);
    check("pass_cnt", o_pass_cnt, ep);
    check("tmo_cnt", o_tmo_cnt, et);
    check("aborted_clear", o_aborted, 0);
    @(negedge clk);
    check("pass_hold", o_pass_cnt, ep);
    check("sb_empty", sb.size(), 0);
    check("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int d0;

    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_cv", o_core_valid, 0);
    check("rst_sel", o_sel, 0);
    check("rst_done", o_done, 0);
    check("rst_resv", o_res_valid, 0);
    check("rst_pass", o_pass_cnt, 0);
    check("rst_tmo", o_tmo_cnt, 0);
    check("rst_abt", o_aborted, 0);
    reset_n = 1'b1;
    @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("idle_abort_done", o_done, 0);
    check("idle_abort_flag", o_aborted, 0);

    run_batch(0, 12, 1'b0);
    run_batch(0, 20, 1'b0);
    run_batch(14, 4, 1'b0);
    dead_sel = 3;
    run_batch(0, 5, 1'b0);
    dead_sel  = -1;
    wrong_sel = 2;
    slow_sel  = 1;
    run_batch(0, 4, 1'b0);
    wrong_sel = -1;
    slow_sel  = -1;
    run_batch(0, 0, 1'b0);
    run_batch(3, 2, 1'b1);

    // Abort during WAIT of image 2: images 0 and 1 report, image 2 must not.
    push_exp(0);
    push_exp(1);
    d0 = done_cnt;
    @(negedge clk);
    i_first_sel = 4'd0;
    i_num_img   = 5'd4;
    i_start     = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    c = 0;
    while (!(o_core_valid && o_sel == 4'd2) && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("abort_reach_img2", o_core_valid && o_sel == 4'd2, 1);
    c = 0;
    while (o_core_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    repeat (5) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_done", o_done, 1);
    check("abort_flag", o_aborted, 1);
    check("abort_busy", o_busy, 0);
    check("abort_pass", o_pass_cnt, 2);
    @(negedge clk);
    check("abort_flag_hold", o_aborted, 1);
    check("abort_sb_empty", sb.size(), 0);
    check("abort_done_once", done_cnt - d0, 1);
    repeat (30) @(negedge clk);
    check("abort_no_late_res", sb.size(), 0);

    // Asynchronous reset in the middle of a batch.
    push_exp(5);
    @(negedge clk);
    i_first_sel = 4'd5;
    i_num_img   = 5'd3;
    i_start     = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("restart_clears_abort", o_aborted, 0);
    c = 0;
    while (!(o_core_valid && o_sel == 4'd6) && c < 500) begin
      @(negedge clk);
      c++;
    end
    while (o_core_valid && c < 600) begin
      @(negedge clk);
      c++;
    end
    repeat (5) @(negedge clk);
    check("pre_rst_pass", o_pass_cnt, 1);
    d0 = done_cnt;
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", o_busy, 0);
    check("arst_sel", o_sel, 0);
    check("arst_pass", o_pass_cnt, 0);
    check("arst_res_sel", o_res_sel, 0);
    check("arst_res_alpha", o_res_alpha, 0);
    sb.delete();
    repeat (5) @(negedge clk);
    check("arst_no_done", done_cnt - d0, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
